gf_serial_host: RTL

- Host-side counterpart of the serial GF-operation wrapper.
- Serializes a parallel reduction polynomial into the wrapper's 1-bit `reduc_in` line, then drives `op_enable` and waits for `op_finish`.
- Deserializes the wrapper's three serial result lines (`out`, `out_poly`, `out_mult`) back into parallel registers.
- Sits between a CPU/testbench register interface and the serial wrapper. Mode/operand inputs (`in_a`, `in_b`, `funct` bits, `in_width`, `polyn_red_in`) bypass this block.

---
 rtl/gf_serial_host_if.sv | 32 +++
 rtl/gf_serial_host.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/gf_serial_host_if.sv
// Signal bundle between gf_serial_host, its register-side requester and the serial GF wrapper.
// The slave modport is the host block itself; master is whatever drives it (CPU side plus wrapper).
interface gf_serial_host_if #(
    parameter int DATA_WIDTH = 32
);
    localparam int W2 = 2 * DATA_WIDTH;

    logic                  start;
    logic [W2-1:0]         reduc_par;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic                  ser_reduc;
    logic                  op_enable;
    logic                  op_finish;
    logic                  ser_out;
    logic                  ser_poly;
    logic                  ser_mult;
    logic [DATA_WIDTH-1:0] res_out;
    logic [DATA_WIDTH-1:0] res_poly;
    logic [W2-1:0]         res_mult;

    modport master (
        output start, reduc_par, op_finish, ser_out, ser_poly, ser_mult,
        input  busy, done, err, ser_reduc, op_enable, res_out, res_poly, res_mult
    );

    modport slave (
        input  start, reduc_par, op_finish, ser_out, ser_poly, ser_mult,
        output busy, done, err, ser_reduc, op_enable, res_out, res_poly, res_mult
    );
endinterface

// File: rtl/gf_serial_host.sv
// Host side of the serial GF wrapper: shifts the reduction polynomial out MSB first,
// handshakes op_enable/op_finish with a timeout, then shifts the three result lines back in.
module gf_serial_host #(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic            clk,
    input  logic            resetn,
    gf_serial_host_if.slave bus
);
    localparam int W2 = 2 * DATA_WIDTH;
    localparam int CW = $clog2(W2);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(W2 - 1);
    localparam logic [CW-1:0] HALF     = CW'(DATA_WIDTH);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_WAIT,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [W2-1:0]         r_shift;
    logic [CW-1:0]         r_bit_cnt;
    logic [TW-1:0]         r_tmo_cnt;
    logic                  r_err;
    logic [DATA_WIDTH-1:0] r_res_out;
    logic [DATA_WIDTH-1:0] r_res_poly;
    logic [W2-1:0]         r_res_mult;
    logic                  w_last_bit;
    logic                  w_tmo_hit;
    logic                  w_busy;
    logic                  w_done;
    logic                  w_op_enable;
    logic                  w_ser_reduc;

    assign w_last_bit = (r_bit_cnt == LAST_BIT);
    assign w_tmo_hit  = (r_tmo_cnt == TMO_LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_busy      = 1'b1;
        w_done      = 1'b0;
        w_op_enable = 1'b0;
        w_ser_reduc = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (bus.start) w_next = S_SHIFT;
            end
            S_SHIFT: begin
                w_ser_reduc = r_shift[W2-1];
                if (w_last_bit) w_next = S_WAIT;
            end
            S_WAIT: begin
                w_op_enable = 1'b1;
                if (bus.op_finish)   w_next = S_CAPTURE;
                else if (w_tmo_hit)  w_next = S_DONE;
            end
            S_CAPTURE: begin
                if (w_last_bit) w_next = S_DONE;
            end
            S_DONE: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // One bit counter serves both SHIFT and CAPTURE; it is re-armed on every entry to either.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_tmo_cnt  <= '0;
            r_err      <= 1'b0;
            r_res_out  <= '0;
            r_res_poly <= '0;
            r_res_mult <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_shift   <= bus.reduc_par;
                        r_err     <= 1'b0;
                        r_bit_cnt <= '0;
                    end
                end
                S_SHIFT: begin
                    r_shift <= {r_shift[W2-2:0], 1'b0};
                    if (w_last_bit) begin
                        r_bit_cnt <= '0;
                        r_tmo_cnt <= '0;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (bus.op_finish) begin
                        r_bit_cnt <= '0;
                    end else if (w_tmo_hit) begin
                        r_err <= 1'b1;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
                end
                S_CAPTURE: begin
                    r_res_mult <= {r_res_mult[W2-2:0], bus.ser_mult};
                    if (r_bit_cnt < HALF) begin
                        r_res_out  <= {r_res_out[DATA_WIDTH-2:0], bus.ser_out};
                        r_res_poly <= {r_res_poly[DATA_WIDTH-2:0], bus.ser_poly};
                    end
                    r_bit_cnt <= w_last_bit ? '0 : r_bit_cnt + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy      = w_busy;
    assign bus.done      = w_done;
    assign bus.err       = r_err;
    assign bus.op_enable = w_op_enable;
    assign bus.ser_reduc = w_ser_reduc;
    assign bus.res_out   = r_res_out;
    assign bus.res_poly  = r_res_poly;
    assign bus.res_mult  = r_res_mult;
endmodule
